mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction-fetch (i_*) and data (d_*) ports share one
// memory bus (m_*). Round-robin arbitration on contention, per-transaction
// timeout with an err pulse, one-cycle completion pulses with held read data.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;
    // Counter value at which one more ack-less cycle means the limit is reached.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_last_owner;
    logic [7:0]  r_cnt;
    logic        r_m_req;
    logic        r_m_we;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_i_valid;
    logic        r_d_valid;
    logic        r_err;

    logic        w_idle;
    logic        w_pick_i;
    logic        w_pick_d;

    // Grant selection: only in IDLE and out of reset; on contention serve the port not served last.
    always_comb begin
        w_idle   = rst && (r_state == S_IDLE);
        w_pick_i = w_idle && i_req && (!d_req || (r_last_owner == OWNER_D));
        w_pick_d = w_idle && d_req && (!i_req || (r_last_owner == OWNER_I));
    end

    assign i_gnt   = w_pick_i;
    assign d_gnt   = w_pick_d;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_valid = r_i_valid;
    assign d_valid = r_d_valid;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign err     = r_err;

    // Arbiter FSM with registered memory-side outputs, completion pulses and timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last_owner <= OWNER_D;
            r_cnt        <= '0;
            r_m_req      <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_valid    <= 1'b0;
            r_d_valid    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_pick_i) begin
                        r_state      <= S_BUSY_I;
                        r_last_owner <= OWNER_I;
                        r_m_req      <= 1'b1;
                        r_m_we       <= 1'b0;
                        r_m_addr     <= i_addr;
                        r_m_wdata    <= '0;
                    end else if (w_pick_d) begin
                        r_state      <= S_BUSY_D;
                        r_last_owner <= OWNER_D;
                        r_m_req      <= 1'b1;
                        r_m_we       <= d_we;
                        r_m_addr     <= d_addr;
                        r_m_wdata    <= d_wdata;
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (m_ack) begin
                        // An ack on the last allowed cycle still counts as success.
                        r_m_req <= 1'b0;
                        r_state <= S_DONE;
                        if (r_state == S_BUSY_I) begin
                            r_i_rdata <= m_rdata;
                            r_i_valid <= 1'b1;
                        end else begin
                            r_d_rdata <= r_m_we ? 32'd0 : m_rdata;
                            r_d_valid <= 1'b1;
                        end
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_m_req <= 1'b0;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a completion scoreboard.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        err;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          port;   // 0 = fetch port, 1 = data port
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t m_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Completion monitor: every valid pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (i_valid === 1'b1 || d_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {30'd0, i_valid, d_valid}, 32'd0);
            end else begin
                m_e = sb.pop_front();
                chk1("sb_d_valid", d_valid, m_e.port);
                chk1("sb_i_valid", i_valid, !m_e.port);
                chk("sb_rdata", m_e.port ? d_rdata : i_rdata, m_e.data);
            end
        end
    end

    // One complete transaction with the memory acking in busy cycle 'lat'.
    task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
        int t;
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        #2;
        t = 0;
        while (((port ? d_gnt : i_gnt) !== 1'b1) && t < 20) begin
            @(posedge clk); #3;
            t++;
        end
        chk1("gnt_seen", t < 20, 1'b1);
        chk1("gnt_other", port ? i_gnt : d_gnt, 1'b0);
        exp_rd = (port && we) ? 32'd0 : rdata;
        sb.push_back('{port, exp_rd});
        @(posedge clk); #1;
        if (port) d_req = 1'b0; else i_req = 1'b0;
        #2;
        for (int k = 1; k <= lat; k++) begin
            chk1("busy_m_req", m_req, 1'b1);
            chk("busy_m_addr", m_addr, addr);
            chk1("busy_m_we", m_we, port ? we : 1'b0);
            chk("busy_m_wdata", m_wdata, port ? wdata : 32'd0);
            chk1("busy_err", err, 1'b0);
            if (k == lat) begin
                m_ack = 1'b1; m_rdata = rdata;
            end
            @(posedge clk); #1;
            m_ack = 1'b0; m_rdata = $urandom;
            #2;
        end
        chk1("done_m_req", m_req, 1'b0);
        chk1("done_own_valid", port ? d_valid : i_valid, 1'b1);
        chk1("done_other_valid", port ? i_valid : d_valid, 1'b0);
        chk("done_rdata", port ? d_rdata : i_rdata, exp_rd);
        chk1("done_err", err, 1'b0);
    endtask

    int t;
    logic want_d;

    initial begin
        // Reset with both requests high: no grant, all outputs zero.
        i_req = 1'b1; d_req = 1'b1;
        @(posedge clk); #3;
        chk1("rst_i_gnt", i_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_m_req", m_req, 1'b0);
        chk1("rst_m_we", m_we, 1'b0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk1("rst_i_valid", i_valid, 1'b0);
        chk1("rst_d_valid", d_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        rst = 1'b1;

        // Single fetch, ack in second busy cycle.
        do_txn(1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 2);
        // Store: read data reported as zero.
        do_txn(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 32'hFFFF_FFFF, 1);
        chk("hold_i_rdata", i_rdata, 32'hDEAD_BEEF);
        // Load on the data port, ack exactly at the timeout limit.
        do_txn(1'b1, 1'b0, 32'h0000_0044, 32'd0, 32'h1234_5678, TO);
        chk("hold_d_rdata", d_rdata, 32'h1234_5678);

        // Contention from reset release: grants alternate I, D, I, D.
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h0000_1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        rst = 1'b1;
        #2;
        for (int g = 0; g < 4; g++) begin
            want_d = (g % 2) == 1;
            t = 0;
            while (!(i_gnt === 1'b1 || d_gnt === 1'b1) && t < 20) begin
                @(posedge clk); #3;
                t++;
            end
            chk1("cont_gnt_seen", t < 20, 1'b1);
            chk1("cont_d_gnt", d_gnt, want_d);
            chk1("cont_i_gnt", i_gnt, !want_d);
            sb.push_back('{want_d, 32'hC000_0000 + 32'(g)});
            @(posedge clk); #3;
            chk("cont_m_addr", m_addr, want_d ? 32'h0000_2000 : 32'h0000_1000);
            m_ack = 1'b1; m_rdata = 32'hC000_0000 + 32'(g);
            @(posedge clk); #1;
            m_ack = 1'b0;
            #2;
            chk1("cont_done_nognt", i_gnt | d_gnt, 1'b0);
            @(posedge clk); #3;
        end
        i_req = 1'b0; d_req = 1'b0;

        // Timeout: memory never acks.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
        #2;
        chk1("to_gnt", d_gnt, 1'b1);
        @(posedge clk); #1;
        d_req = 1'b0;
        #2;
        for (int k = 0; k < TO; k++) begin
            chk1("to_busy_m_req", m_req, 1'b1);
            chk1("to_busy_err", err, 1'b0);
            @(posedge clk); #3;
        end
        chk1("to_err", err, 1'b1);
        chk1("to_m_req", m_req, 1'b0);
        chk1("to_no_valid", d_valid, 1'b0);
        @(posedge clk); #3;
        chk1("to_err_pulse", err, 1'b0);
        do_txn(1'b0, 1'b0, 32'h0000_0200, 32'd0, 32'hA5A5_0001, 1);

        // Spurious ack while idle.
        @(posedge clk); #1;
        m_ack = 1'b1; m_rdata = 32'h0BAD_0BAD;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk1("spur_m_req", m_req, 1'b0);
            chk1("spur_err", err, 1'b0);
            @(posedge clk); #3;
        end
        m_ack = 1'b0;
        do_txn(1'b1, 1'b0, 32'h0000_0300, 32'd0, 32'h7777_0002, 2);

        // Reset during BUSY_D aborts the transaction.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
        #2;
        chk1("rb_gnt", d_gnt, 1'b1);
        @(posedge clk); #1;
        d_req = 1'b0;
        #2;
        chk1("rb_busy", m_req, 1'b1);
        rst = 1'b0;
        @(posedge clk); #3;
        chk1("rb_m_req", m_req, 1'b0);
        chk1("rb_d_valid", d_valid, 1'b0);
        chk1("rb_err", err, 1'b0);
        chk("rb_m_addr", m_addr, 32'd0);
        i_req = 1'b1; i_addr = 32'h0000_5000;
        #1;
        chk1("rb_no_gnt", i_gnt, 1'b0);
        @(posedge clk); #3;
        chk1("rb_no_gnt2", i_gnt, 1'b0);
        chk1("rb_no_valid2", d_valid, 1'b0);
        i_req = 1'b0;
        rst = 1'b1;
        do_txn(1'b0, 1'b0, 32'h0000_5000, 32'd0, 32'h5A5A_0003, 1);

        @(posedge clk); #3;
        @(posedge clk); #3;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
